ibex_ex_seq_ctrl: RTL and testbench
===================================

IBEX_EX_SEQ_CTRL -- requirements
Module: ibex_ex_seq_ctrl

Interface
REQ-001 The block SHALL have parameter VxsatEn, bit, default 1: 1 = sticky vxsat register implemented; 0 = vxsat_o tied 0.
REQ-002 The block SHALL have port clk_i, input, 1: the single clock.
REQ-003 The block SHALL have port rst_ni, input, 1: reset, synchronous, active-low.
REQ-004 The block SHALL have port instr_valid_i, input, 1: ID issues a valid instruction to EX.
REQ-005 The block SHALL have port mult_sel_i / div_sel_i, input, 1 each: static decoder selects for multiply / divide.
REQ-006 The block SHALL have port kill_i, input, 1: flush; abort the current instruction.
REQ-007 The block SHALL have port ex_valid_i, input, 1: EX result valid this cycle.
REQ-008 The block SHALL have port wb_ready_i, input, 1: writeback accepts the result this cycle.
REQ-009 The block SHALL have port imd_val_we_i, input, 2: per-register intermediate write enables from EX.
REQ-010 The block SHALL have port imd_val_d_i[2], input, 34 each: intermediate write data.
REQ-011 The block SHALL have port imd_val_q_o[2], output, 34 each: registered intermediate values to EX.
REQ-012 The block SHALL have port vxsat_set_i, input, 1: EX saturation flag for the current instruction.
REQ-013 The block SHALL have ports csr_vxsat_we_i and csr_vxsat_wdata_i, input, 1 each: CSR write to vxsat.
REQ-014 The block SHALL have outputs alu_instr_first_cycle_o, mult_en_o, div_en_o and multdiv_ready_id_o, 1 each: EX control.
REQ-015 The block SHALL have outputs instr_done_o, 1: completion pulse; and stall_o, 1: ID must hold the instruction.
REQ-016 The block SHALL have outputs vxsat_o, 1: sticky saturation flag; and ex_cycles_o, 6: cycle count of the current or last instruction.

Function
REQ-017 FSM states SHALL be IDLE, BUSY and HOLD.
REQ-018 "Active" SHALL mean (IDLE and instr_valid_i) or BUSY or HOLD.
REQ-019 alu_instr_first_cycle_o SHALL be 1 only in IDLE with instr_valid_i=1.
REQ-020 IDLE with instr_valid_i=1, kill_i=0, ex_valid_i=1 and wb_ready_i=1: instr_done_o=1 and the state SHALL stay IDLE (zero-bubble back-to-back issue).
REQ-021 IDLE with ex_valid_i=1 and wb_ready_i=0 SHALL go to HOLD; IDLE with ex_valid_i=0 SHALL go to BUSY.
REQ-022 BUSY: ex_valid_i=1 and wb_ready_i=1 SHALL pulse instr_done_o and go to IDLE; ex_valid_i=1 and wb_ready_i=0 SHALL go to HOLD; otherwise the state SHALL stay BUSY.
REQ-023 HOLD: wb_ready_i=1 SHALL pulse instr_done_o and go to IDLE; ex_valid_i is ignored in HOLD.
REQ-024 stall_o SHALL be Active and not instr_done_o; it SHALL be combinational.
REQ-025 mult_en_o SHALL be Active and mult_sel_i and not kill_i; div_en_o SHALL be the same with div_sel_i.
REQ-026 multdiv_ready_id_o SHALL equal wb_ready_i.
REQ-027 kill_i=1 in any state SHALL force next state IDLE, SHALL suppress instr_done_o and imd writes that cycle, and SHALL clear no other register.
REQ-028 imd_val_q_o[i] SHALL load imd_val_d_i[i] at the clock edge when imd_val_we_i[i] is set, Active holds and kill_i=0; otherwise it SHALL hold its value.
REQ-029 Both imd registers SHALL be written in the same cycle when imd_val_we_i=2'b11.
REQ-030 imd_val_q_o SHALL be a register output with no combinational path from imd_val_d_i.
REQ-031 ex_cycles_o SHALL load 1 on the first cycle, increment each later Active cycle, saturate at 63, and hold after done or kill.
REQ-032 vxsat next value SHALL be csr_vxsat_wdata_i when csr_vxsat_we_i=1 (CSR write wins); otherwise vxsat_o | (instr_done_o & vxsat_set_i).
REQ-033 vxsat_set_i SHALL be sampled only in the instr_done_o cycle, and SHALL never be sampled on kill.
REQ-034 Simultaneous instr_valid_i and kill_i in IDLE SHALL leave the state IDLE; alu_instr_first_cycle_o still asserts and no register updates occur.

Reset
REQ-035 With rst_ni=0 at a clock edge, the following SHALL hold next cycle: state IDLE, imd_val_q_o both 34'h0, vxsat_o=0, ex_cycles_o=0.
REQ-036 During reset, instr_done_o, stall_o, mult_en_o and div_en_o SHALL be 0 regardless of inputs.
REQ-037 Reset asserted mid-instruction (BUSY or HOLD) SHALL abort the instruction without a done pulse and without a vxsat update.

Verification
REQ-038 Single-cycle ALU: instr_valid=1, ex_valid=1, wb_ready=1 for 3 consecutive cycles -> 3 done pulses, stall=0 throughout, ex_cycles=1.
REQ-039 Multicycle mult: mult_sel=1, imd_we=2'b01 with d=34'h3_0000_0001 at cycle 1, ex_valid at cycle 3 -> imd_q[0]=34'h3_0000_0001 from cycle 2, done at cycle 3, ex_cycles=3.
REQ-040 Writeback backpressure: ex_valid=1 with wb_ready=0 for 4 cycles -> HOLD, stall=1 and multdiv_ready_id=0; wb_ready=1 -> one done, then IDLE.
REQ-041 Kill in BUSY with imd_we=2'b11 -> no done, imd_q unchanged, IDLE next cycle, mult_en=0 in the kill cycle.
REQ-042 vxsat: done with vxsat_set=1 -> vxsat_o=1; CSR write 0 in the same cycle as a later done with set=1 -> vxsat_o=0; kill with set=1 -> vxsat_o unchanged.
REQ-043 Counter saturation: BUSY held for 70 cycles -> ex_cycles=63; rst_ni=0 mid-BUSY -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/ibex_ex_seq_ctrl.sv
// Execute-stage sequencing controller: tracks single/multi-cycle instructions,
// writeback backpressure, intermediate-value registers and the sticky vxsat flag.
//
// state | meaning
// IDLE  | no instruction in flight; a valid issue may complete in the same cycle
// BUSY  | multi-cycle instruction waiting for ex_valid_i
// HOLD  | result ready, waiting for writeback to accept it
module ibex_ex_seq_ctrl #(
  parameter bit VxsatEn = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  input  logic        mult_sel_i,
  input  logic        div_sel_i,
  input  logic        kill_i,
  input  logic        ex_valid_i,
  input  logic        wb_ready_i,
  input  logic [1:0]  imd_val_we_i,
  input  logic [33:0] imd_val_d_i [2],
  output logic [33:0] imd_val_q_o [2],
  input  logic        vxsat_set_i,
  input  logic        csr_vxsat_we_i,
  input  logic        csr_vxsat_wdata_i,
  output logic        alu_instr_first_cycle_o,
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        multdiv_ready_id_o,
  output logic        instr_done_o,
  output logic        stall_o,
  output logic        vxsat_o,
  output logic [5:0]  ex_cycles_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        active, first_cycle, done_raw, update_en;
  logic [5:0]  ex_cycles_q;
  logic [33:0] imd_val_q [2];

  assign first_cycle = (state_q == IDLE) && instr_valid_i;
  assign active      = first_cycle || (state_q == BUSY) || (state_q == HOLD);
  assign update_en   = active && !kill_i;

  always_comb begin
    state_d  = state_q;
    done_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid_i) begin
          if (ex_valid_i) begin
            if (wb_ready_i) done_raw = 1'b1;
            else            state_d  = HOLD;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (ex_valid_i) begin
          if (wb_ready_i) begin
            done_raw = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // ex_valid_i is irrelevant once the result is parked here
        if (wb_ready_i) begin
          done_raw = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (kill_i) begin
      state_d  = IDLE;
      done_raw = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Handshake outputs are forced low while reset is held
  assign instr_done_o            = done_raw && rst_ni;
  assign stall_o                 = active && !done_raw && rst_ni;
  assign mult_en_o               = update_en && mult_sel_i && rst_ni;
  assign div_en_o                = update_en && div_sel_i && rst_ni;
  assign multdiv_ready_id_o      = wb_ready_i;
  assign alu_instr_first_cycle_o = first_cycle;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) imd_val_q[i] <= 34'h0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (imd_val_we_i[i] && update_en) imd_val_q[i] <= imd_val_d_i[i];
      end
    end
  end

  assign imd_val_q_o = imd_val_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ex_cycles_q <= 6'd0;
    end else if (update_en) begin
      if (first_cycle)               ex_cycles_q <= 6'd1;
      else if (ex_cycles_q != 6'd63) ex_cycles_q <= ex_cycles_q + 6'd1;
    end
  end

  assign ex_cycles_o = ex_cycles_q;

  if (VxsatEn) begin : g_vxsat
    logic vxsat_q;
    always_ff @(posedge clk_i) begin
      if (!rst_ni)             vxsat_q <= 1'b0;
      else if (csr_vxsat_we_i) vxsat_q <= csr_vxsat_wdata_i;
      else if (instr_done_o)   vxsat_q <= vxsat_q | vxsat_set_i;
    end
    assign vxsat_o = vxsat_q;
  end else begin : g_no_vxsat
    assign vxsat_o = 1'b0;
  end

endmodule

// File: tb/tb_ibex_ex_seq_ctrl.sv
// Directed self-checking bench for ibex_ex_seq_ctrl.
module tb_ibex_ex_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_valid_i, mult_sel_i, div_sel_i, kill_i;
  logic        ex_valid_i, wb_ready_i;
  logic [1:0]  imd_val_we_i;
  logic [33:0] imd_val_d_i [2];
  logic [33:0] imd_val_q_o [2];
  logic        vxsat_set_i, csr_vxsat_we_i, csr_vxsat_wdata_i;
  logic        alu_instr_first_cycle_o, mult_en_o, div_en_o, multdiv_ready_id_o;
  logic        instr_done_o, stall_o, vxsat_o;
  logic [5:0]  ex_cycles_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  always #5 clk_i = ~clk_i;

  ibex_ex_seq_ctrl dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .instr_valid_i           (instr_valid_i),
    .mult_sel_i              (mult_sel_i),
    .div_sel_i               (div_sel_i),
    .kill_i                  (kill_i),
    .ex_valid_i              (ex_valid_i),
    .wb_ready_i              (wb_ready_i),
    .imd_val_we_i            (imd_val_we_i),
    .imd_val_d_i             (imd_val_d_i),
    .imd_val_q_o             (imd_val_q_o),
    .vxsat_set_i             (vxsat_set_i),
    .csr_vxsat_we_i          (csr_vxsat_we_i),
    .csr_vxsat_wdata_i       (csr_vxsat_wdata_i),
    .alu_instr_first_cycle_o (alu_instr_first_cycle_o),
    .mult_en_o               (mult_en_o),
    .div_en_o                (div_en_o),
    .multdiv_ready_id_o      (multdiv_ready_id_o),
    .instr_done_o            (instr_done_o),
    .stall_o                 (stall_o),
    .vxsat_o                 (vxsat_o),
    .ex_cycles_o             (ex_cycles_o)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // advance one clock; registered outputs are sampled 1ns after the edge
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs;
    instr_valid_i     = 1'b0;
    mult_sel_i        = 1'b0;
    div_sel_i         = 1'b0;
    kill_i            = 1'b0;
    ex_valid_i        = 1'b0;
    wb_ready_i        = 1'b0;
    imd_val_we_i      = 2'b00;
    imd_val_d_i[0]    = 34'h0;
    imd_val_d_i[1]    = 34'h0;
    vxsat_set_i       = 1'b0;
    csr_vxsat_we_i    = 1'b0;
    csr_vxsat_wdata_i = 1'b0;
  endtask

  initial begin
    // reset with aggressive inputs: handshake outputs must stay low
    idle_inputs();
    rst_ni = 1'b0;
    instr_valid_i = 1'b1; ex_valid_i = 1'b1; wb_ready_i = 1'b1;
    mult_sel_i = 1'b1; div_sel_i = 1'b1; vxsat_set_i = 1'b1;
    #1;
    chk("rst_done",  instr_done_o, 1'b0);
    chk("rst_stall", stall_o,      1'b0);
    chk("rst_mult",  mult_en_o,    1'b0);
    chk("rst_div",   div_en_o,     1'b0);
    tick();
    chk("rst_imd0",  imd_val_q_o[0], 34'h0);
    chk("rst_imd1",  imd_val_q_o[1], 34'h0);
    chk("rst_vxsat", vxsat_o,        1'b0);
    chk("rst_cyc",   ex_cycles_o,    6'd0);
    idle_inputs();
    rst_ni = 1'b1;
    tick();

    // three back-to-back single-cycle ALU ops
    instr_valid_i = 1'b1; ex_valid_i = 1'b1; wb_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (instr_done_o) n_done++;
      chk("alu_stall", stall_o, 1'b0);
      chk("alu_first", alu_instr_first_cycle_o, 1'b1);
      tick();
      chk("alu_cyc", ex_cycles_o, 6'd1);
    end
    chk("alu_ndone", n_done, 3);
    idle_inputs();

    // multicycle multiply, result at cycle 3
    instr_valid_i = 1'b1; mult_sel_i = 1'b1; wb_ready_i = 1'b1;
    imd_val_we_i = 2'b01;
    imd_val_d_i[0] = 34'h3_0000_0001; imd_val_d_i[1] = 34'h2_AAAA_5555;
    #1;
    chk("mul1_en",    mult_en_o,    1'b1);
    chk("mul1_stall", stall_o,      1'b1);
    chk("mul1_done",  instr_done_o, 1'b0);
    tick();
    chk("mul1_imd0", imd_val_q_o[0], 34'h3_0000_0001);
    chk("mul1_imd1", imd_val_q_o[1], 34'h0);
    chk("mul1_cyc",  ex_cycles_o,    6'd1);
    instr_valid_i = 1'b0; imd_val_we_i = 2'b00;
    #1;
    chk("mul2_stall", stall_o, 1'b1);
    chk("mul2_en",    mult_en_o, 1'b1);
    chk("mul2_first", alu_instr_first_cycle_o, 1'b0);
    tick();
    chk("mul2_cyc", ex_cycles_o, 6'd2);
    ex_valid_i = 1'b1;
    #1;
    chk("mul3_done",  instr_done_o, 1'b1);
    chk("mul3_stall", stall_o,      1'b0);
    tick();
    chk("mul3_cyc",  ex_cycles_o,    6'd3);
    chk("mul3_imd0", imd_val_q_o[0], 34'h3_0000_0001);
    idle_inputs();
    #1;
    chk("mul_idle_stall", stall_o, 1'b0);
    chk("mul_idle_en",    mult_en_o, 1'b0);

    // writeback backpressure into HOLD
    instr_valid_i = 1'b1; div_sel_i = 1'b1; ex_valid_i = 1'b1; wb_ready_i = 1'b0;
    #1;
    chk("bp_div",   div_en_o, 1'b1);
    chk("bp_stall", stall_o, 1'b1);
    chk("bp_rdy",   multdiv_ready_id_o, 1'b0);
    tick();
    instr_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_stall", stall_o, 1'b1);
      chk("hold_rdy",   multdiv_ready_id_o, 1'b0);
      chk("hold_done",  instr_done_o, 1'b0);
      tick();
    end
    chk("hold_cyc", ex_cycles_o, 6'd4);
    wb_ready_i = 1'b1; ex_valid_i = 1'b0;
    #1;
    chk("hold_rel_done",  instr_done_o, 1'b1);
    chk("hold_rel_rdy",   multdiv_ready_id_o, 1'b1);
    chk("hold_rel_stall", stall_o, 1'b0);
    tick();
    chk("hold_rel_cyc", ex_cycles_o, 6'd5);
    idle_inputs();
    #1;
    chk("bp_idle_stall", stall_o, 1'b0);

    // issue together with kill in IDLE: first-cycle flag only, nothing updates
    instr_valid_i = 1'b1; kill_i = 1'b1; mult_sel_i = 1'b1; ex_valid_i = 1'b1;
    wb_ready_i = 1'b1; imd_val_we_i = 2'b11; vxsat_set_i = 1'b1;
    imd_val_d_i[0] = 34'h0_DEAD_BEEF; imd_val_d_i[1] = 34'h1_0000_0007;
    #1;
    chk("ik_first", alu_instr_first_cycle_o, 1'b1);
    chk("ik_mult",  mult_en_o,    1'b0);
    chk("ik_done",  instr_done_o, 1'b0);
    tick();
    chk("ik_cyc",   ex_cycles_o,    6'd5);
    chk("ik_imd0",  imd_val_q_o[0], 34'h3_0000_0001);
    chk("ik_imd1",  imd_val_q_o[1], 34'h0);
    chk("ik_vxsat", vxsat_o,        1'b0);
    idle_inputs();

    // kill in BUSY with both imd enables
    instr_valid_i = 1'b1; mult_sel_i = 1'b1;
    #1;
    chk("kb_first", alu_instr_first_cycle_o, 1'b1);
    tick();
    instr_valid_i = 1'b0; kill_i = 1'b1; imd_val_we_i = 2'b11;
    imd_val_d_i[0] = 34'h1_2345_6789; imd_val_d_i[1] = 34'h0_FFFF_0000;
    ex_valid_i = 1'b1; wb_ready_i = 1'b1; vxsat_set_i = 1'b1;
    #1;
    chk("kb_done", instr_done_o, 1'b0);
    chk("kb_mult", mult_en_o,    1'b0);
    tick();
    chk("kb_imd0",  imd_val_q_o[0], 34'h3_0000_0001);
    chk("kb_imd1",  imd_val_q_o[1], 34'h0);
    chk("kb_cyc",   ex_cycles_o,    6'd1);
    chk("kb_vxsat", vxsat_o,        1'b0);
    // back in IDLE: single-cycle op writes both imd regs and sets vxsat
    kill_i = 1'b0; instr_valid_i = 1'b1; mult_sel_i = 1'b0;
    #1;
    chk("kb_idle_first", alu_instr_first_cycle_o, 1'b1);
    chk("kb_idle_done",  instr_done_o, 1'b1);
    tick();
    chk("both_imd0", imd_val_q_o[0], 34'h1_2345_6789);
    chk("both_imd1", imd_val_q_o[1], 34'h0_FFFF_0000);
    chk("vx_set",    vxsat_o, 1'b1);

    // CSR write of 0 wins over a done with set=1
    imd_val_we_i = 2'b00; csr_vxsat_we_i = 1'b1; csr_vxsat_wdata_i = 1'b0;
    #1;
    chk("vx_csr_done", instr_done_o, 1'b1);
    tick();
    chk("vx_csr_win", vxsat_o, 1'b0);
    // kill with set=1 leaves vxsat alone
    csr_vxsat_we_i = 1'b0; kill_i = 1'b1;
    tick();
    chk("vx_kill", vxsat_o, 1'b0);
    // CSR write 1 while idle, then a done without set keeps it sticky
    idle_inputs();
    csr_vxsat_we_i = 1'b1; csr_vxsat_wdata_i = 1'b1;
    tick();
    chk("vx_csr1", vxsat_o, 1'b1);
    idle_inputs();
    instr_valid_i = 1'b1; ex_valid_i = 1'b1; wb_ready_i = 1'b1;
    tick();
    chk("vx_sticky", vxsat_o, 1'b1);
    idle_inputs();

    // counter saturation in a long BUSY
    instr_valid_i = 1'b1; mult_sel_i = 1'b1;
    tick();
    instr_valid_i = 1'b0;
    for (int k = 1; k < 70; k++) begin
      tick();
      if (k == 61) chk("sat_62", ex_cycles_o, 6'd62);
      if (k == 62) chk("sat_63", ex_cycles_o, 6'd63);
    end
    chk("sat_70", ex_cycles_o, 6'd63);
    chk("sat_stall", stall_o, 1'b1);

    // reset mid-BUSY with a completing result presented
    rst_ni = 1'b0; ex_valid_i = 1'b1; wb_ready_i = 1'b1; vxsat_set_i = 1'b1;
    #1;
    chk("mr_done",  instr_done_o, 1'b0);
    chk("mr_stall", stall_o,      1'b0);
    chk("mr_mult",  mult_en_o,    1'b0);
    tick();
    chk("mr_cyc",   ex_cycles_o,    6'd0);
    chk("mr_vxsat", vxsat_o,        1'b0);
    chk("mr_imd0",  imd_val_q_o[0], 34'h0);
    chk("mr_imd1",  imd_val_q_o[1], 34'h0);
    idle_inputs();
    rst_ni = 1'b1;
    #1;
    chk("mr_idle_stall", stall_o, 1'b0);
    instr_valid_i = 1'b1;
    #1;
    chk("mr_idle_first", alu_instr_first_cycle_o, 1'b1);
    tick();
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
